// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC channel scheduler: FSM encoding,
// mode/channel codes and UART frame packing helpers.
package adc_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StStart,
        StWaitSpi,
        StSendHi,
        StSendLo
    } sched_state_e;

    localparam logic [1:0] MODE_TEMP = 2'b00;
    localparam logic [1:0] MODE_LDR  = 2'b01;
    localparam logic [1:0] MODE_ALT  = 2'b10;

    localparam logic CH_TEMP = 1'b0;
    localparam logic CH_LDR  = 1'b1;

    localparam int unsigned FRM_CH_BIT     = 7;
    localparam int unsigned FRM_HI_NIB_MSB = 3;
    localparam int unsigned FRM_HI_NIB_LSB = 0;

    // Modes 10 and 11 both alternate, so only the upper mode bit matters.
    function automatic logic is_alt_mode(input logic [1:0] mode);
        return (mode & MODE_ALT) != 2'b00;
    endfunction

    function automatic logic sel_channel(input logic [1:0] mode, input logic alt_ch);
        logic ch;
        if (mode == MODE_TEMP) begin
            ch = CH_TEMP;
        end else if (mode == MODE_LDR) begin
            ch = CH_LDR;
        end else begin
            ch = alt_ch;
        end
        return ch;
    endfunction

    function automatic logic [7:0] hi_byte(input logic ch, input logic [11:0] data);
        logic [7:0] b;
        b = 8'h00;
        b[FRM_CH_BIT] = ch;
        b[FRM_HI_NIB_MSB:FRM_HI_NIB_LSB] = data[11:8];
        return b;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Periodic sample tick: counts while enabled and emits a registered one-cycle
// pulse on wrap, so the first tick lands SAMPLE_PERIOD_CYC cycles after enable.
module sample_tick_gen #(
    parameter int unsigned SAMPLE_PERIOD_CYC = 50000
) (
    input  logic Clk_i,
    input  logic Reset_i,
    input  logic Enable_i,
    output logic Tick_o
);

    localparam int unsigned   CntW   = $clog2(SAMPLE_PERIOD_CYC);
    localparam logic [CntW-1:0] CntMax = CntW'(SAMPLE_PERIOD_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;
    logic            wrap;

    always_comb begin
        wrap   = Enable_i && (cnt_q == CntMax);
        tick_d = wrap;
        cnt_d  = '0;
        if (Enable_i && !wrap) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign Tick_o = tick_q;

endmodule

// File: rtl/adc_channel_scheduler.sv
// Sequences periodic conversions on the shared SPI ADC, captures each sample
// and streams it to the UART as a two-byte frame over valid/ready.
module adc_channel_scheduler
    import adc_sched_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD_CYC = 50000,
    parameter int unsigned SPI_TIMEOUT_CYC   = 1024,
    parameter int unsigned DATA_W            = 12
) (
    input  logic              Clk_i,
    input  logic              Reset_i,
    input  logic              Enable_i,
    input  logic [1:0]        Mode_i,
    input  logic              Err_clr_i,
    output logic              Spi_start_o,
    output logic              Spi_ch_o,
    input  logic              Spi_done_i,
    input  logic [DATA_W-1:0] Spi_data_i,
    output logic [DATA_W-1:0] Sample_data_o,
    output logic              Sample_ch_o,
    output logic              Sample_valid_o,
    output logic [7:0]        Tx_data_o,
    output logic              Tx_valid_o,
    input  logic              Tx_ready_i,
    output logic              Overrun_o,
    output logic              Timeout_o
);

    localparam int unsigned TmoW = (SPI_TIMEOUT_CYC > 1) ? $clog2(SPI_TIMEOUT_CYC) : 1;
    localparam logic [TmoW-1:0] TmoMax = TmoW'(SPI_TIMEOUT_CYC - 1);

    sched_state_e state_q, state_d;

    logic              tick;
    logic              ch_q, ch_d;
    logic              alt_ch_q, alt_ch_d;
    logic              start_ch;
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [DATA_W-1:0] sample_data_q, sample_data_d;
    logic              sample_ch_q, sample_ch_d;
    logic              sample_valid_q, sample_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic              timeout_set;
    logic              tx_hs;
    logic              tmo_expire;

    sample_tick_gen #(
        .SAMPLE_PERIOD_CYC(SAMPLE_PERIOD_CYC)
    ) u_tick_gen (
        .Clk_i   (Clk_i),
        .Reset_i (Reset_i),
        .Enable_i(Enable_i),
        .Tick_o  (tick)
    );

    assign tx_hs      = tx_valid_q && Tx_ready_i;
    assign tmo_expire = (tmo_cnt_q == TmoMax);
    assign start_ch   = sel_channel(Mode_i, alt_ch_q);

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (Enable_i) state_d = StWaitTick;
            StWaitTick: begin
                if (!Enable_i) begin
                    state_d = StIdle;
                end else if (tick) begin
                    state_d = StStart;
                end
            end
            StStart:    state_d = StWaitSpi;
            // done takes priority over a simultaneous timeout expiry
            StWaitSpi: begin
                if (Spi_done_i) begin
                    state_d = StSendHi;
                end else if (tmo_expire) begin
                    state_d = StWaitTick;
                end
            end
            StSendHi:   if (tx_hs) state_d = StSendLo;
            StSendLo:   if (tx_hs) state_d = Enable_i ? StWaitTick : StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Channel is driven combinationally in START so Mode_i is sampled there only.
    always_comb begin
        Spi_start_o = (state_q == StStart);
        Spi_ch_o    = (state_q == StStart) ? start_ch : ch_q;
    end

    always_comb begin
        ch_d           = ch_q;
        alt_ch_d       = alt_ch_q;
        tmo_cnt_d      = tmo_cnt_q;
        sample_data_d  = sample_data_q;
        sample_ch_d    = sample_ch_q;
        sample_valid_d = 1'b0;
        tx_data_d      = tx_data_q;
        tx_valid_d     = tx_valid_q;
        timeout_set    = 1'b0;
        unique case (state_q)
            StStart: begin
                ch_d      = start_ch;
                tmo_cnt_d = '0;
                if (is_alt_mode(Mode_i)) begin
                    alt_ch_d = ~alt_ch_q;
                end
            end
            StWaitSpi: begin
                if (Spi_done_i) begin
                    sample_data_d  = Spi_data_i;
                    sample_ch_d    = ch_q;
                    sample_valid_d = 1'b1;
                    tx_data_d      = hi_byte(ch_q, Spi_data_i);
                    tx_valid_d     = 1'b1;
                end else if (tmo_expire) begin
                    timeout_set = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
            end
            StSendHi: if (tx_hs) tx_data_d = sample_data_q[7:0];
            StSendLo: if (tx_hs) tx_valid_d = 1'b0;
            default: ;
        endcase
        overrun_d = (tick && (state_q != StWaitTick)) || (overrun_q && !Err_clr_i);
        timeout_d = timeout_set || (timeout_q && !Err_clr_i);
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            ch_q           <= CH_TEMP;
            alt_ch_q       <= CH_TEMP;
            tmo_cnt_q      <= '0;
            sample_data_q  <= '0;
            sample_ch_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            tx_data_q      <= 8'h00;
            tx_valid_q     <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            ch_q           <= ch_d;
            alt_ch_q       <= alt_ch_d;
            tmo_cnt_q      <= tmo_cnt_d;
            sample_data_q  <= sample_data_d;
            sample_ch_q    <= sample_ch_d;
            sample_valid_q <= sample_valid_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
        end
    end

    assign Sample_data_o  = sample_data_q;
    assign Sample_ch_o    = sample_ch_q;
    assign Sample_valid_o = sample_valid_q;
    assign Tx_data_o      = tx_data_q;
    assign Tx_valid_o     = tx_valid_q;
    assign Overrun_o      = overrun_q;
    assign Timeout_o      = timeout_q;

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Directed bench for adc_channel_scheduler with a short sample period and
// SPI timeout; the SPI and UART sides are driven inline from one initial block.
module tb_adc_channel_scheduler;

    localparam int unsigned PER = 16;
    localparam int unsigned TMO = 32;

    logic        Clk_i      = 1'b0;
    logic        Reset_i    = 1'b1;
    logic        Enable_i   = 1'b0;
    logic [1:0]  Mode_i     = 2'b00;
    logic        Err_clr_i  = 1'b0;
    logic        Spi_done_i = 1'b0;
    logic [11:0] Spi_data_i = 12'h000;
    logic        Tx_ready_i = 1'b1;

    logic        Spi_start_o;
    logic        Spi_ch_o;
    logic [11:0] Sample_data_o;
    logic        Sample_ch_o;
    logic        Sample_valid_o;
    logic [7:0]  Tx_data_o;
    logic        Tx_valid_o;
    logic        Overrun_o;
    logic        Timeout_o;

    logic [26:0] all_outs;
    assign all_outs = {Spi_start_o, Spi_ch_o, Sample_data_o, Sample_ch_o, Sample_valid_o,
                       Tx_data_o, Tx_valid_o, Overrun_o, Timeout_o};

    int n_checks = 0;
    int n_fail   = 0;

    adc_channel_scheduler #(
        .SAMPLE_PERIOD_CYC(PER),
        .SPI_TIMEOUT_CYC  (TMO),
        .DATA_W           (12)
    ) dut (
        .Clk_i         (Clk_i),
        .Reset_i       (Reset_i),
        .Enable_i      (Enable_i),
        .Mode_i        (Mode_i),
        .Err_clr_i     (Err_clr_i),
        .Spi_start_o   (Spi_start_o),
        .Spi_ch_o      (Spi_ch_o),
        .Spi_done_i    (Spi_done_i),
        .Spi_data_i    (Spi_data_i),
        .Sample_data_o (Sample_data_o),
        .Sample_ch_o   (Sample_ch_o),
        .Sample_valid_o(Sample_valid_o),
        .Tx_data_o     (Tx_data_o),
        .Tx_valid_o    (Tx_valid_o),
        .Tx_ready_i    (Tx_ready_i),
        .Overrun_o     (Overrun_o),
        .Timeout_o     (Timeout_o)
    );

    always #5 Clk_i = ~Clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk_i);
        #1;
    endtask

    // Reset is released 1 time unit after a rising edge, with Enable_i already high.
    task automatic do_reset(input logic [1:0] mode);
        Reset_i    = 1'b1;
        Enable_i   = 1'b1;
        Mode_i     = mode;
        Spi_done_i = 1'b0;
        Err_clr_i  = 1'b0;
        Tx_ready_i = 1'b1;
        step();
        step();
        Reset_i = 1'b0;
    endtask

    task automatic wait_start(input string tag, output int n);
        n = 0;
        while (Spi_start_o !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk({tag, " start_seen"}, 32'(Spi_start_o), 32'd1);
    endtask

    task automatic conv(input string tag, input int lat, input logic [11:0] d, input logic ch,
                        input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        int n;
        wait_start(tag, n);
        chk({tag, " spi_ch"}, 32'(Spi_ch_o), 32'(ch));
        repeat (lat) step();
        chk({tag, " spi_ch_hold"}, 32'(Spi_ch_o), 32'(ch));
        Spi_done_i = 1'b1;
        Spi_data_i = d;
        step();
        Spi_done_i = 1'b0;
        Spi_data_i = 12'hFFF;
        chk({tag, " sample_valid"}, 32'(Sample_valid_o), 32'd1);
        chk({tag, " sample_data"}, 32'(Sample_data_o), 32'(d));
        chk({tag, " sample_ch"}, 32'(Sample_ch_o), 32'(ch));
        chk({tag, " tx_valid_hi"}, 32'(Tx_valid_o), 32'd1);
        chk({tag, " tx_hi"}, 32'(Tx_data_o), 32'(exp_hi));
        step();
        chk({tag, " sample_valid_pulse"}, 32'(Sample_valid_o), 32'd0);
        chk({tag, " tx_valid_lo"}, 32'(Tx_valid_o), 32'd1);
        chk({tag, " tx_lo"}, 32'(Tx_data_o), 32'(exp_lo));
        step();
        chk({tag, " tx_valid_drop"}, 32'(Tx_valid_o), 32'd0);
    endtask

    initial begin
        int         n;
        logic       stable;
        logic       no_valid;
        int         nb;
        logic [7:0] bytes [4];

        // Reset state
        step();
        chk("reset_outputs", 32'(all_outs), 32'd0);

        // Mode 00, conversion longer than the period -> tick lands in WAIT_SPI
        do_reset(2'b00);
        chk("m00 overrun_init", 32'(Overrun_o), 32'd0);
        conv("m00", 20, 12'h02B, 1'b0, 8'h00, 8'h2B);
        chk("m00 overrun", 32'(Overrun_o), 32'd1);
        Err_clr_i = 1'b1;
        step();
        Err_clr_i = 1'b0;
        chk("m00 overrun_clr", 32'(Overrun_o), 32'd0);

        // Alternate mode: channels 0,1,0
        do_reset(2'b10);
        conv("alt0", 4, 12'h02B, 1'b0, 8'h00, 8'h2B);
        conv("alt1", 4, 12'hABC, 1'b1, 8'h8A, 8'hBC);
        wait_start("alt2", n);
        chk("alt2 spi_ch", 32'(Spi_ch_o), 32'd0);
        chk("alt overrun", 32'(Overrun_o), 32'd0);

        // UART back-pressure during the high byte
        do_reset(2'b00);
        Tx_ready_i = 1'b0;
        wait_start("bp", n);
        repeat (4) step();
        Spi_done_i = 1'b1;
        Spi_data_i = 12'h5A3;
        step();
        Spi_done_i = 1'b0;
        chk("bp tx_valid", 32'(Tx_valid_o), 32'd1);
        chk("bp tx_hi", 32'(Tx_data_o), 32'h05);
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (Tx_valid_o !== 1'b1 || Tx_data_o !== 8'h05) stable = 1'b0;
        end
        chk("bp stable", 32'(stable), 32'd1);
        chk("bp overrun", 32'(Overrun_o), 32'd1);
        Tx_ready_i = 1'b1;
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            if (Tx_valid_o === 1'b1 && Tx_ready_i === 1'b1) begin
                if (nb < 4) bytes[nb] = Tx_data_o;
                nb++;
            end
            step();
        end
        chk("bp byte_count", 32'(nb), 32'd2);
        chk("bp byte0", 32'(bytes[0]), 32'h05);
        chk("bp byte1", 32'(bytes[1]), 32'hA3);

        // SPI never answers: timeout, no frame, FSM returns to waiting for a tick
        do_reset(2'b01);
        wait_start("tmo", n);
        chk("tmo spi_ch", 32'(Spi_ch_o), 32'd1);
        no_valid = 1'b1;
        for (int i = 0; i < 31; i++) begin
            step();
            if (Tx_valid_o !== 1'b0) no_valid = 1'b0;
        end
        chk("tmo flag_early", 32'(Timeout_o), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            if (Tx_valid_o !== 1'b0) no_valid = 1'b0;
        end
        chk("tmo flag", 32'(Timeout_o), 32'd1);
        chk("tmo no_frame", 32'(no_valid), 32'd1);
        wait_start("tmo_next", n);
        chk("tmo_next spi_ch", 32'(Spi_ch_o), 32'd1);
        Err_clr_i = 1'b1;
        step();
        Err_clr_i = 1'b0;
        chk("tmo clr", 32'(Timeout_o), 32'd0);

        // Done on the exact expiry cycle wins over the timeout
        do_reset(2'b00);
        wait_start("edge", n);
        repeat (32) step();
        Spi_done_i = 1'b1;
        Spi_data_i = 12'h3C7;
        step();
        Spi_done_i = 1'b0;
        chk("edge tx_valid", 32'(Tx_valid_o), 32'd1);
        chk("edge tx_hi", 32'(Tx_data_o), 32'h03);
        chk("edge sample", 32'(Sample_data_o), 32'h3C7);
        chk("edge timeout", 32'(Timeout_o), 32'd0);
        step();
        chk("edge tx_lo", 32'(Tx_data_o), 32'hC7);
        step();
        chk("edge tx_done", 32'(Tx_valid_o), 32'd0);
        chk("edge timeout_after", 32'(Timeout_o), 32'd0);

        // Reset mid-frame drops outputs asynchronously; restart latency
        do_reset(2'b00);
        wait_start("rst", n);
        repeat (4) step();
        Spi_done_i = 1'b1;
        Spi_data_i = 12'h123;
        step();
        Spi_done_i = 1'b0;
        chk("rst tx_valid_pre", 32'(Tx_valid_o), 32'd1);
        Reset_i = 1'b1;
        #1;
        chk("rst async_outputs", 32'(all_outs), 32'd0);
        step();
        Reset_i = 1'b0;
        wait_start("rst_restart", n);
        chk("rst restart_latency", 32'(n), 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_channel_scheduler.md
Name: adc_channel_scheduler

Overview:
Sequences periodic 12-bit conversions on the shared SPI ADC between the temperature channel (ch 0) and the LDR channel (ch 1). Issues start requests to the SPI master and captures the returned sample. Packs each sample into a 2-byte frame and hands it to the UART transmitter over a valid/ready handshake. Sits between the switch/mode logic and the SPI/UART IPs inside Top_Tmp_Ldr.

Parameters:
SAMPLE_PERIOD_CYC, 50000, clocks between sample ticks (1 kHz at 50 MHz); legal range 8..2^20.
SPI_TIMEOUT_CYC, 1024, maximum clocks to wait for Spi_done_i after a start.
DATA_W, 12, ADC sample width; fixed at 12 for frame packing.

Ports:
Clk_i  in  1  system clock
Reset_i  in  1  asynchronous, active-high reset
Enable_i  in  1  level; 1 = periodic sampling runs
Mode_i  in  2  00 temp only, 01 LDR only, 10/11 alternate (starts with temp)
Err_clr_i  in  1  pulse; clears sticky error flags
Spi_start_o  out  1  one-cycle start pulse to SPI master
Spi_ch_o  out  1  ADC channel for the current conversion; stable from start until done
Spi_done_i  in  1  one-cycle pulse from SPI master; Spi_data_i is valid in that cycle
Spi_data_i  in  12  conversion result
Sample_data_o  out  12  last captured sample
Sample_ch_o  out  1  channel of the last sample
Sample_valid_o  out  1  one-cycle pulse when Sample_data_o updates
Tx_data_o  out  8  UART byte
Tx_valid_o  out  1  byte valid; held until accepted
Tx_ready_i  in  1  UART accepts the byte when Tx_valid_o && Tx_ready_i
Overrun_o  out  1  sticky; a tick arrived while the FSM was busy
Timeout_o  out  1  sticky; the SPI did not respond within SPI_TIMEOUT_CYC

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; period counter 0; next channel 0.
- Tick generator: while Enable_i=1, counts 0..SAMPLE_PERIOD_CYC-1 and pulses tick at wrap. It is held at 0 while Enable_i=0, so the first tick comes SAMPLE_PERIOD_CYC cycles after enable.
- FSM states: IDLE, WAIT_TICK, START, WAIT_SPI, SEND_HI, SEND_LO.
- IDLE: if Enable_i=1, go to WAIT_TICK.
- WAIT_TICK: on tick, go to START. If Enable_i=0, go to IDLE.
- START: Spi_start_o=1 for exactly one cycle. Spi_ch_o is set in this cycle from Mode_i and the channel toggle. Go to WAIT_SPI and clear the timeout counter.
- WAIT_SPI: on Spi_done_i, perform the capture below, then go to SEND_HI.
  - Capture: Sample_data_o <= Spi_data_i and Sample_ch_o <= Spi_ch_o.
  - Next cycle: Sample_valid_o=1 and Tx_data_o = {ch, 3'b000, data[11:8]} with Tx_valid_o=1.
  - Latency from done to Tx_valid_o is 1 cycle.
- WAIT_SPI timeout: when the counter reaches SPI_TIMEOUT_CYC-1 without done, set Timeout_o, emit no frame, and go to WAIT_TICK. If done and expiry fall in the same cycle, done wins.
- SEND_HI: hold Tx_data_o/Tx_valid_o until handshake. On the handshake cycle, load Tx_data_o = data[7:0] and go to SEND_LO; Tx_valid_o stays 1.
- SEND_LO: on handshake, drop Tx_valid_o. Go to WAIT_TICK if Enable_i=1, else IDLE.
- Channel selection:
  - Mode 00 always selects 0; mode 01 always selects 1.
  - Alternate mode toggles the channel after every START, including conversions that later time out.
  - Mode_i is sampled only in START; a change mid-conversion affects the next conversion.
- Overrun: a tick in any state other than WAIT_TICK sets Overrun_o. The tick is dropped and not queued.
- Enable_i=0 mid-operation: the current conversion and frame complete; there is no abort.
- Spi_done_i outside WAIT_SPI is ignored.
- Err_clr_i clears both flags; a set event in the same cycle wins.
- Reset mid-frame: immediate return to reset values; a partial frame is abandoned and Tx_valid_o drops asynchronously.

Decomposition:
- Package adc_sched_pkg: FSM state encoding; MODE_TEMP/MODE_LDR/MODE_ALT constants; CH_TEMP=0, CH_LDR=1; frame field positions (FRM_CH_BIT=7, FRM_HI_NIB=3:0).
- Sub-module sample_tick_gen (parameter SAMPLE_PERIOD_CYC; inputs Clk_i, Reset_i, Enable_i; output Tick_o). The rest stays in one FSM module.

Test Plan:
All scenarios use SAMPLE_PERIOD_CYC=16 and SPI_TIMEOUT_CYC=32.
- Mode 00, Enable_i=1, SPI model returns 12'd43 (0x02B) 20 cycles after start -> Spi_ch_o=0; Sample_data_o=0x02B; UART bytes 0x00 then 0x2B; Sample_valid_o pulses once.
- Mode 10, SPI returns 0x02B then 0xABC -> Spi_ch_o sequence 0,1,0; frames {0x00,0x2B} and {0x8A,0xBC}.
- Tx_ready_i held 0 for 40 cycles during SEND_HI -> Tx_data_o/Tx_valid_o stable; next tick sets Overrun_o=1; exactly 2 bytes are sent after release.
- SPI never returns done -> Timeout_o=1 32 cycles after start; no Tx_valid_o; FSM in WAIT_TICK; Err_clr_i pulse -> Timeout_o=0.
- Spi_done_i on the exact expiry cycle -> frame sent and Timeout_o stays 0.
- Reset_i asserted while Tx_valid_o=1 -> all outputs 0 immediately; after release with Enable_i=1, the first Spi_start_o comes 17 cycles later.
